// File: rtl/inst_mem_loader.sv
// inst_mem_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
// cpu_hold keeps the processor's PC frozen for the whole session.
module inst_mem_loader #(
  parameter int DEPTH_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [DEPTH_W:0]   len_i,
  input  logic               abort_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  output logic               byte_ready_o,
  output logic               mem_we_o,
  output logic [DEPTH_W-1:0] mem_addr_o,
  output logic [31:0]        mem_wdata_o,
  output logic               cpu_hold_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [DEPTH_W:0]   words_loaded_o
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t           state_q;
  logic [DEPTH_W:0] len_q;
  logic [DEPTH_W:0] cnt_q;
  logic [1:0]       lane_q;
  logic [31:0]      wdata_q;
  // word counter doubles as words_loaded: both clear on start and step on each write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          len_q   <= len_i;
          cnt_q   <= '0;
          lane_q  <= '0;
          state_q <= (len_i == '0) ? DONE : RECV;
        end
        RECV: if (abort_i) state_q <= IDLE;
        else if (byte_valid_i) begin
          wdata_q[{lane_q, 3'b000} +: 8] <= byte_i;
          lane_q <= lane_q + 2'd1;
          if (lane_q == 2'd3) state_q <= WRITE;
        end
        WRITE: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= abort_i ? IDLE : (cnt_q + 1'b1 == len_q) ? DONE : RECV;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign byte_ready_o   = state_q == RECV;
  assign mem_we_o       = state_q == WRITE;
  assign done_o         = state_q == DONE;
  assign busy_o         = state_q != IDLE;
  assign cpu_hold_o     = state_q != IDLE;
  assign mem_addr_o     = cnt_q[DEPTH_W-1:0];
  assign mem_wdata_o    = wdata_q;
  assign words_loaded_o = cnt_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed self-checking bench for inst_mem_loader.
module tb_inst_mem_loader;
  localparam int DW = 6;
  logic          clk = 0, rst_n = 0, start = 0, abort = 0, byte_valid = 0;
  logic [DW:0]   len = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_ready, mem_we, cpu_hold, busy, done;
  logic [DW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [DW:0]   words_loaded;
  int            checks = 0, errors = 0, wr_n = 0, wr0;

  inst_mem_loader #(.DEPTH_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .abort_i(abort),
    .byte_i(byte_in), .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .cpu_hold_o(cpu_hold), .busy_o(busy), .done_o(done), .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (mem_we) wr_n++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input int l);
    start = 1;
    len = l[DW:0];
    tick();
    start = 0;
  endtask

  // feeds four bytes (optionally with an idle cycle before each) and checks the following write cycle
  task automatic send_word(input logic [31:0] w, input int addr, input bit stall);
    for (int k = 0; k < 4; k++) begin
      if (stall) begin
        byte_valid = 0;
        tick();
      end
      byte_valid = 1;
      byte_in = w[8*k +: 8];
      chk("byte_ready", byte_ready, 1);
      tick();
    end
    byte_valid = 0;
    chk("we", mem_we, 1);
    chk("addr", mem_addr, addr);
    chk("wdata", mem_wdata, w);
    chk("ready_in_write", byte_ready, 0);
    chk("hold_in_write", cpu_hold, 1);
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, 8'hA5, ~b, 8'h3C};
  endfunction

  initial begin
    #12;
    chk("rst_we", mem_we, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_words", words_loaded, 0);
    rst_n = 1;
    tick();
    // zero-length session
    wr0 = wr_n;
    begin_session(0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 1);
    chk("len0_words", words_loaded, 0);
    tick();
    chk("len0_done_off", done, 0);
    chk("len0_idle", busy, 0);
    chk("len0_nowrite", wr_n - wr0, 0);
    // single word
    begin_session(1);
    chk("l1_hold", cpu_hold, 1);
    send_word(32'h00500093, 0, 0);
    tick();
    chk("l1_done", done, 1);
    chk("l1_we_off", mem_we, 0);
    chk("l1_words", words_loaded, 1);
    tick();
    chk("l1_done_off", done, 0);
    chk("l1_hold_off", cpu_hold, 0);
    chk("l1_words_hold", words_loaded, 1);
    // three words with byte_valid toggling
    wr0 = wr_n;
    begin_session(3);
    for (int i = 0; i < 3; i++) begin
      send_word(32'h1000_0000 * (i + 1) + 32'h00C0FFEE, i, 1);
      tick();
      chk("l3_hold", cpu_hold, 1);
    end
    chk("l3_done", done, 1);
    chk("l3_words", words_loaded, 3);
    chk("l3_writes", wr_n - wr0, 3);
    tick();
    // abort in RECV mid-word
    wr0 = wr_n;
    begin_session(2);
    send_word(32'hDEADBEEF, 0, 0);
    tick();
    byte_valid = 1;
    byte_in = 8'h11;
    tick();
    byte_in = 8'h22;
    tick();
    byte_valid = 0;
    abort = 1;
    tick();
    abort = 0;
    chk("ab_busy", busy, 0);
    chk("ab_hold", cpu_hold, 0);
    chk("ab_done", done, 0);
    chk("ab_words", words_loaded, 1);
    chk("ab_writes", wr_n - wr0, 1);
    // abort during WRITE: that write still lands
    wr0 = wr_n;
    begin_session(2);
    send_word(32'hCAFEF00D, 0, 0);
    abort = 1;
    tick();
    abort = 0;
    chk("abw_busy", busy, 0);
    chk("abw_done", done, 0);
    chk("abw_words", words_loaded, 1);
    chk("abw_writes", wr_n - wr0, 1);
    // start outside IDLE is ignored
    begin_session(1);
    start = 1;
    len = 7'd5;
    tick();
    start = 0;
    send_word(32'h0BADF00D, 0, 0);
    tick();
    chk("ign_done", done, 1);
    chk("ign_words", words_loaded, 1);
    tick();
    // reset asserted during WRITE of word 2 of len=4
    begin_session(4);
    for (int i = 0; i < 3; i++) begin
      send_word(pat(i), i, 0);
      if (i < 2) tick();
    end
    #2 rst_n = 0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_hold", cpu_hold, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_words", words_loaded, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    begin_session(1);
    send_word(32'h12345678, 0, 0);
    tick();
    chk("post_rst_done", done, 1);
    tick();
    // full depth, stall-free: every address once, 5 cycles per word
    wr0 = wr_n;
    begin_session(1 << DW);
    for (int i = 0; i < (1 << DW); i++) begin
      send_word(pat(i), i, 0);
      tick();
    end
    chk("full_done", done, 1);
    chk("full_words", words_loaded, 1 << DW);
    chk("full_writes", wr_n - wr0, 1 << DW);
    tick();
    chk("full_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
